manchester_rx_deframer: RTL and testbench

- Receive-side counterpart of the Manchester serial transmitter.
- Takes 8-chip parallel words from the ISERDESE2 (1:8 DDR, clk_div domain), finds chip and byte alignment by matching the encoded preamble+SFD, and Manchester-decodes the payload into bytes.
- Sits between the ISERDESE2 Q outputs and the byte-level consumer logic, and flags coding violations.

---
 rtl/manchester_rx_deframer.sv | 187 ++++++++++++++++++
 tb/tb_manchester_rx_deframer.sv | 391 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/manchester_rx_deframer.sv
// manchester_rx_deframer
// Receive-side Manchester deframer for a 1:8 ISERDES chip stream. Hunts for the
// encoded preamble+SFD at any of the 8 chip offsets, then decodes 16-chip groups
// into payload bytes (bit 1 = chips "10", bit 0 = chips "01", MSB first).
// Pairs "00"/"11" abort the frame with a one-cycle code_err strobe.

module manchester_rx_deframer #(
    parameter logic [7:0] PREAMBLE    = 8'hAA,
    parameter logic [7:0] SFD         = 8'hD5,
    parameter int         PAYLOAD_LEN = 6
) (
    input  logic       clk_div,
    input  logic       rst,
    input  logic [7:0] chips_in,
    input  logic       chips_valid,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       sof,
    output logic       eof,
    output logic       locked,
    output logic [2:0] chip_offset,
    output logic       code_err
);

    // Manchester encoding of one byte, first chip of each pair in the higher bit.
    function automatic logic [15:0] encode_byte(input logic [7:0] b);
        logic [15:0] e;
        e = '0;
        for (int i = 0; i < 8; i++) begin
            e[15-2*i] = b[7-i];
            e[14-2*i] = ~b[7-i];
        end
        return e;
    endfunction

    // Data bit of each pair is its first chip.
    function automatic logic [7:0] decode_group(input logic [15:0] g);
        logic [7:0] d;
        d = '0;
        for (int i = 0; i < 8; i++) begin
            d[7-i] = g[15-2*i];
        end
        return d;
    endfunction

    // A pair with two equal chips is not a legal Manchester symbol.
    function automatic logic group_has_violation(input logic [15:0] g);
        logic v;
        v = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (g[15-2*i] == g[14-2*i]) begin
                v = 1'b1;
            end
        end
        return v;
    endfunction

    // 32-chip sync pattern: encoded preamble byte followed by encoded SFD.
    localparam logic [31:0] SYNC      = {encode_byte(PREAMBLE), encode_byte(SFD)};
    localparam logic [7:0]  LAST_BYTE = 8'(PAYLOAD_LEN - 1);

    typedef enum logic {
        HUNT = 1'b0,
        RECV = 1'b1
    } state_t;

    state_t      state;
    logic [31:0] hist;        // last four valid words, oldest chip in bit 31
    logic [39:0] window;      // history plus the current word
    logic [23:0] buffer;      // decode buffer, valid chips right-aligned
    logic [4:0]  buf_cnt;     // number of unconsumed chips in buffer
    logic [7:0]  byte_cnt;    // payload byte index within the frame

    logic        match_found;
    logic [2:0]  match_k;

    logic [31:0] combined;    // buffer chips followed by the incoming word
    logic [5:0]  total;       // chips available in combined
    logic [5:0]  shamt;       // shift that brings the oldest 16 chips to the bottom
    logic [15:0] group;
    logic        have_group;
    logic        group_bad;
    logic [7:0]  group_byte;
    logic        last_byte;

    assign window = {hist, chips_in};

    // Sync search over all eight chip offsets; the lowest offset takes priority.
    always_comb begin
        match_found = 1'b0;
        match_k     = 3'd0;
        for (int k = 7; k >= 0; k--) begin
            if (window[39-k -: 32] == SYNC) begin
                match_found = 1'b1;
                match_k     = 3'(k);
            end
        end
    end

    // Oldest 16 unconsumed chips and their decode, valid when have_group is set.
    assign combined   = {buffer[23:0], chips_in};
    assign total      = {1'b0, buf_cnt} + 6'd8;
    assign shamt      = total - 6'd16;
    assign group      = 16'(combined >> shamt);
    assign have_group = (total >= 6'd16);
    assign group_bad  = group_has_violation(group);
    assign group_byte = decode_group(group);
    assign last_byte  = (byte_cnt == LAST_BYTE);

    // Chip history shifts on every valid word regardless of state.
    always_ff @(posedge clk_div or posedge rst) begin
        if (rst) begin
            hist <= '0;
        end else if (chips_valid) begin
            hist <= window[31:0];
        end
    end

    // Hunt/receive state machine with registered strobes and decode buffer.
    always_ff @(posedge clk_div or posedge rst) begin
        if (rst) begin
            state       <= HUNT;
            buffer      <= '0;
            buf_cnt     <= '0;
            byte_cnt    <= '0;
            data_out    <= 8'h00;
            data_valid  <= 1'b0;
            sof         <= 1'b0;
            eof         <= 1'b0;
            locked      <= 1'b0;
            chip_offset <= 3'd0;
            code_err    <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            sof        <= 1'b0;
            eof        <= 1'b0;
            code_err   <= 1'b0;
            if (chips_valid) begin
                case (state)
                    HUNT: begin
                        if (match_found) begin
                            // chips after the pattern are the start of the payload
                            state       <= RECV;
                            locked      <= 1'b1;
                            chip_offset <= match_k;
                            byte_cnt    <= '0;
                            buffer      <= {16'h0000, chips_in};
                            buf_cnt     <= 5'd8 - {2'b00, match_k};
                        end
                    end
                    RECV: begin
                        buffer <= combined[23:0];
                        if (!have_group) begin
                            buf_cnt <= total[4:0];
                        end else if (group_bad) begin
                            code_err <= 1'b1;
                            state    <= HUNT;
                            locked   <= 1'b0;
                            byte_cnt <= '0;
                            buf_cnt  <= '0;
                        end else begin
                            data_valid <= 1'b1;
                            data_out   <= group_byte;
                            sof        <= (byte_cnt == 8'd0);
                            eof        <= last_byte;
                            if (last_byte) begin
                                // leftover chips of a finished frame are dropped
                                state    <= HUNT;
                                locked   <= 1'b0;
                                byte_cnt <= '0;
                                buf_cnt  <= '0;
                            end else begin
                                byte_cnt <= byte_cnt + 8'd1;
                                buf_cnt  <= shamt[4:0];
                            end
                        end
                    end
                    default: begin
                        state  <= HUNT;
                        locked <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_manchester_rx_deframer.sv
// Testbench for manchester_rx_deframer: a fixed k=0 vector table, directed
// multi-cycle sequences and randomized frames checked cycle by cycle against a
// chip-queue reference model.

module tb_manchester_rx_deframer;

    localparam logic [7:0] PREAMBLE    = 8'hAA;
    localparam logic [7:0] SFD         = 8'hD5;
    localparam int         PAYLOAD_LEN = 6;

    logic       clk_div;
    logic       rst;
    logic [7:0] chips_in;
    logic       chips_valid;
    logic [7:0] data_out;
    logic       data_valid;
    logic       sof;
    logic       eof;
    logic       locked;
    logic [2:0] chip_offset;
    logic       code_err;

    manchester_rx_deframer #(
        .PREAMBLE   (PREAMBLE),
        .SFD        (SFD),
        .PAYLOAD_LEN(PAYLOAD_LEN)
    ) dut (
        .clk_div    (clk_div),
        .rst        (rst),
        .chips_in   (chips_in),
        .chips_valid(chips_valid),
        .data_out   (data_out),
        .data_valid (data_valid),
        .sof        (sof),
        .eof        (eof),
        .locked     (locked),
        .chip_offset(chip_offset),
        .code_err   (code_err)
    );

    initial clk_div = 1'b0;
    always #5 clk_div = ~clk_div;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] outs_now();
        return {data_valid, sof, eof, code_err, locked, chip_offset, data_out};
    endfunction

    // ---------------- reference model ----------------
    bit         pbits[32];
    bit         win[$];       // last 40 chips seen on valid cycles
    bit         dq[$];        // unconsumed payload chips
    bit         hunting;
    int         nbytes;
    logic [7:0] e_data;
    logic       e_dv, e_sof, e_eof, e_err;
    logic [2:0] e_off;

    function automatic logic [15:0] model_outs();
        return {e_dv, e_sof, e_eof, e_err, ~hunting, e_off, e_data};
    endfunction

    task automatic model_reset();
        win.delete();
        for (int i = 0; i < 32; i++) win.push_back(1'b0);
        dq.delete();
        hunting = 1'b1;
        nbytes  = 0;
        e_data  = 8'h00;
        e_dv    = 1'b0;
        e_sof   = 1'b0;
        e_eof   = 1'b0;
        e_err   = 1'b0;
        e_off   = 3'd0;
    endtask

    task automatic model_step(input logic [7:0] w, input bit v);
        bit         found;
        bit         same;
        bit         bad;
        logic [7:0] b;
        e_dv  = 1'b0;
        e_sof = 1'b0;
        e_eof = 1'b0;
        e_err = 1'b0;
        if (!v) return;
        for (int i = 7; i >= 0; i--) win.push_back(w[i]);
        while (win.size() > 40) void'(win.pop_front());
        if (hunting) begin
            found = 1'b0;
            for (int k = 0; k < 8; k++) begin
                if (!found) begin
                    same = 1'b1;
                    for (int j = 0; j < 32; j++) if (win[k+j] != pbits[j]) same = 1'b0;
                    if (same) begin
                        found   = 1'b1;
                        hunting = 1'b0;
                        e_off   = 3'(k);
                        nbytes  = 0;
                        dq.delete();
                        for (int j = k + 32; j < 40; j++) dq.push_back(win[j]);
                    end
                end
            end
        end else begin
            for (int i = 7; i >= 0; i--) dq.push_back(w[i]);
            if (dq.size() >= 16) begin
                bad = 1'b0;
                b   = 8'h00;
                for (int j = 0; j < 8; j++) begin
                    if (dq[2*j] == dq[2*j+1]) bad = 1'b1;
                    b[7-j] = dq[2*j];
                end
                if (bad) begin
                    e_err   = 1'b1;
                    hunting = 1'b1;
                    dq.delete();
                end else begin
                    e_dv   = 1'b1;
                    e_data = b;
                    e_sof  = (nbytes == 0);
                    e_eof  = (nbytes == PAYLOAD_LEN - 1);
                    nbytes++;
                    if (e_eof) begin
                        hunting = 1'b1;
                        dq.delete();
                    end else begin
                        repeat (16) void'(dq.pop_front());
                    end
                end
            end
        end
    endtask

    // ---------------- monitor tallies ----------------
    int         n_dv, n_sof, n_eof, n_err;
    logic [2:0] last_off;
    logic       prev_locked;

    task automatic clr_counts();
        n_dv  = 0;
        n_sof = 0;
        n_eof = 0;
        n_err = 0;
    endtask

    task automatic tally();
        if (data_valid) n_dv++;
        if (sof) n_sof++;
        if (eof) n_eof++;
        if (code_err) n_err++;
        if (locked && !prev_locked) last_off = chip_offset;
        prev_locked = locked;
    endtask

    // One word clock: drive at the falling edge, sample at the next falling edge.
    task automatic cycle(input logic [7:0] w, input bit v);
        chips_in    = w;
        chips_valid = v;
        model_step(w, v);
        @(posedge clk_div);
        @(negedge clk_div);
        check("cycle_outputs", {16'h0000, outs_now()}, {16'h0000, model_outs()});
        tally();
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        chips_valid = 1'b0;
        #1;
        check("reset_outputs", {16'h0000, outs_now()}, 32'h0);
        model_reset();
        @(posedge clk_div);
        @(negedge clk_div);
        rst         = 1'b0;
        prev_locked = 1'b0;
    endtask

    // ---------------- chip stream builder ----------------
    bit stream[$];

    task automatic add_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            stream.push_back(b[i]);
            stream.push_back(~b[i]);
        end
    endtask

    task automatic add_filler(input int n);
        for (int i = 0; i < n; i++) stream.push_back(bit'(i % 2));
    endtask

    task automatic add_std_frame();
        add_byte(PREAMBLE);
        add_byte(PREAMBLE);
        add_byte(SFD);
        add_byte(8'hAA);
        add_byte(8'hBB);
        add_byte(8'hCC);
        add_byte(8'hDD);
        add_byte(8'hEE);
        add_byte(8'hFF);
    endtask

    // mode 0: valid every cycle, 1: valid toggles 1/0, 2: random idle gaps.
    task automatic flush(input int mode, input int reset_at);
        int nw;
        while (stream.size() % 8 != 0) stream.push_back(bit'(stream.size() % 2));
        nw = stream.size() / 8;
        for (int i = 0; i < nw; i++) begin
            logic [7:0] w;
            for (int j = 0; j < 8; j++) w[7-j] = stream[8*i+j];
            if (i == reset_at) do_reset();
            if (mode == 2) begin
                while ($urandom_range(0, 3) == 0) cycle(8'($urandom), 1'b0);
            end
            cycle(w, 1'b1);
            if (mode == 1) cycle(8'($urandom), 1'b0);
        end
        cycle(8'h55, 1'b1);
        cycle(8'h55, 1'b1);
        stream.delete();
    endtask

    // ---------------- fixed vector table (k = 0 frame) ----------------
    typedef struct {
        logic [7:0] w;
        logic       dv;
        logic [7:0] d;
        logic       s;
        logic       e;
        logic       lk;
    } vec_t;

    vec_t tbl[20];

    function automatic vec_t mk(input logic [7:0] w, input logic dv, input logic [7:0] d,
                                input logic s, input logic e, input logic lk);
        vec_t r;
        r.w  = w;
        r.dv = dv;
        r.d  = d;
        r.s  = s;
        r.e  = e;
        r.lk = lk;
        return r;
    endfunction

    initial begin
        logic [7:0] pre;
        logic [7:0] sfd;
        int         start;
        logic [7:0] pb;

        pre = PREAMBLE;
        sfd = SFD;
        for (int i = 0; i < 8; i++) begin
            pbits[2*i]        = pre[7-i];
            pbits[2*i+1]      = ~pre[7-i];
            pbits[16+2*i]     = sfd[7-i];
            pbits[16+2*i+1]   = ~sfd[7-i];
        end

        // encode(AA AA D5) = 99 99 99 99 A6 66, then AA BB CC DD EE FF
        tbl[0]  = mk(8'h99, 0, 8'h00, 0, 0, 0);
        tbl[1]  = mk(8'h99, 0, 8'h00, 0, 0, 0);
        tbl[2]  = mk(8'h99, 0, 8'h00, 0, 0, 0);
        tbl[3]  = mk(8'h99, 0, 8'h00, 0, 0, 0);
        tbl[4]  = mk(8'hA6, 0, 8'h00, 0, 0, 0);
        tbl[5]  = mk(8'h66, 0, 8'h00, 0, 0, 0);
        tbl[6]  = mk(8'h99, 0, 8'h00, 0, 0, 1);
        tbl[7]  = mk(8'h99, 1, 8'hAA, 1, 0, 1);
        tbl[8]  = mk(8'h9A, 0, 8'hAA, 0, 0, 1);
        tbl[9]  = mk(8'h9A, 1, 8'hBB, 0, 0, 1);
        tbl[10] = mk(8'hA5, 0, 8'hBB, 0, 0, 1);
        tbl[11] = mk(8'hA5, 1, 8'hCC, 0, 0, 1);
        tbl[12] = mk(8'hA6, 0, 8'hCC, 0, 0, 1);
        tbl[13] = mk(8'hA6, 1, 8'hDD, 0, 0, 1);
        tbl[14] = mk(8'hA9, 0, 8'hDD, 0, 0, 1);
        tbl[15] = mk(8'hA9, 1, 8'hEE, 0, 0, 1);
        tbl[16] = mk(8'hAA, 0, 8'hEE, 0, 0, 1);
        tbl[17] = mk(8'hAA, 1, 8'hFF, 0, 1, 0);
        tbl[18] = mk(8'h55, 0, 8'hFF, 0, 0, 0);
        tbl[19] = mk(8'h55, 0, 8'hFF, 0, 0, 0);

        rst         = 1'b0;
        chips_in    = 8'h00;
        chips_valid = 1'b0;
        prev_locked = 1'b0;
        last_off    = 3'd0;
        clr_counts();
        @(negedge clk_div);
        do_reset();

        // Aligned frame from the vector table.
        for (int i = 0; i < 20; i++) begin
            chips_in    = tbl[i].w;
            chips_valid = 1'b1;
            @(posedge clk_div);
            @(negedge clk_div);
            check($sformatf("vec%0d", i), {16'h0000, outs_now()},
                  {16'h0000, tbl[i].dv, tbl[i].s, tbl[i].e, 1'b0, tbl[i].lk, 3'd0, tbl[i].d});
        end

        // Offsets 3 and 7 via leading filler chips.
        do_reset();
        clr_counts();
        add_filler(3);
        add_std_frame();
        flush(0, -1);
        check("k3_offset", {29'h0, last_off}, 32'd3);
        check("k3_eof_count", n_eof, 1);
        clr_counts();
        add_filler(7);
        add_std_frame();
        flush(0, -1);
        check("k7_offset", {29'h0, last_off}, 32'd7);
        check("k7_byte_count", n_dv, 6);

        // chips_valid toggling every cycle.
        clr_counts();
        add_std_frame();
        flush(1, -1);
        check("toggle_byte_count", n_dv, 6);
        check("toggle_sof_count", n_sof, 1);
        check("toggle_eof_count", n_eof, 1);

        // Violation in byte CC, followed by a clean frame.
        clr_counts();
        start = stream.size();
        add_std_frame();
        stream[start + 48 + 32 + 4] = ~stream[start + 48 + 32 + 4];
        add_std_frame();
        flush(0, -1);
        check("viol_err_count", n_err, 1);
        check("viol_byte_count", n_dv, 8);
        check("viol_eof_count", n_eof, 1);

        // Reset right after byte BB, then a full frame.
        clr_counts();
        add_std_frame();
        flush(0, 10);
        check("rst_mid_byte_count", n_dv, 2);
        check("rst_mid_eof_count", n_eof, 0);
        clr_counts();
        add_std_frame();
        flush(0, -1);
        check("rst_after_byte_count", n_dv, 6);

        // Continuous transmit loop, four back-to-back frames.
        clr_counts();
        for (int i = 0; i < 4; i++) add_std_frame();
        flush(0, -1);
        check("loop_eof_count", n_eof, 4);
        check("loop_sof_count", n_sof, 4);
        check("loop_byte_count", n_dv, 24);

        // Randomized frames, offsets, payloads, gaps and occasional violations.
        for (int f = 0; f < 40; f++) begin
            add_filler($urandom_range(0, 20));
            start = stream.size();
            add_byte(PREAMBLE);
            add_byte(PREAMBLE);
            add_byte(SFD);
            for (int b = 0; b < PAYLOAD_LEN; b++) begin
                pb = 8'($urandom);
                add_byte(pb);
            end
            if ($urandom_range(0, 4) == 0) begin
                int idx;
                idx = start + 48 + $urandom_range(0, 16 * PAYLOAD_LEN - 1);
                stream[idx] = ~stream[idx];
            end
            flush(2, -1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
